mask_unit_read_collector: RTL
=============================

# mask_unit_read_collector

Per-group read sequencer and collector for the mask unit. It accepts one group command covering four slots, issues up to four VRF read requests onto the slot channels of the mask-unit read crossbar (slot i drives crossbar input i, so writeIndex == i), and gathers the tagged lane responses into a 4-entry data buffer. When every enabled slot has returned, it presents the assembled group downstream.

## Interface
Parameters:
- DATA_W, 32, width of one lane read response.
- Slot count is fixed at 4; readLane, offset, dataOffset and writeIndex are 2 bits; vs is 5 bits.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  group command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_bits_vs  in  5  source register, shared by all slots.
- cmd_bits_offset  in  2  register offset, shared.
- cmd_bits_mask  in  4  slot enable; bit i enables slot i.
- cmd_bits_readLane  in  8  packed {slot3..slot0}, 2 bits each.
- cmd_bits_dataOffset  in  8  packed {slot3..slot0}, 2 bits each.
- readReq_i_valid  out  1  i=0..3; to crossbar input_i_valid.
- readReq_i_ready  in  1  from crossbar input_i_ready.
- readReq_i_bits_vs/offset/readLane/dataOffset  out  5/2/2/2  registered copies of the command fields for slot i.
- readResp_valid  in  4  bit L: response from lane L this cycle.
- readResp_writeIndex  in  8  packed per lane; destination slot.
- readResp_data  in  4*DATA_W  packed per lane.
- out_valid  out  1  assembled group available.
- out_ready  in  1  downstream accept.
- out_bits_data  out  4*DATA_W  slot i at [i*DATA_W +: DATA_W].
- out_bits_mask  out  4  echo of cmd_bits_mask.
- error  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: on cmd fire, latch all command fields, clear issued[3:0], got[3:0] and the data buffer. Go to DONE if cmd_bits_mask==0, otherwise go to BUSY.
- BUSY: readReq_i_valid = mask[i] & ~issued[i]. issued[i] sets on readReq_i fire. Once set, a slot is never re-requested. Valid stays high until it is accepted; request fields stay stable.
- Response handling applies in BUSY only. For each lane L with readResp_valid[L], let w = writeIndex[L]. If mask[w] & issued[w] & ~got[w], write the data into buf[w] and set got[w]. Otherwise drop the response and set error.
- If two lanes target the same w in one cycle, the lowest lane wins and error is set.
- A response for slot w arriving in the same cycle as slot w's request fire is a violation: it is dropped and error is set.
- BUSY to DONE at the edge where got_next == mask.
- DONE: out_valid=1. out_bits are driven from the buffer; unreturned or disabled slots read as 0. On out_ready, go to IDLE.
- Responses arriving in IDLE or DONE are dropped and set error.
- error clears only on reset.

## Timing
- Reset values: state=IDLE, issued=got=0, buffer=0, error=0, all readReq valids=0, out_valid=0, cmd_ready=1.
- Reset asserted mid-group aborts immediately. No outputs glitch other than returning to the reset values.
- Cmd fires in cycle 0. readReq valids are high from cycle 1.
- A response sampled at the end of cycle t that completes the mask gives out_valid in cycle t+1.
- Best case, with all requests accepted in cycle 1 and single-cycle lanes returning in cycle 2, out_valid is seen in cycle 3.
- mask==0: out_valid in cycle 1.
- DONE to IDLE costs one cycle, so the minimum command spacing is one bubble: cmd_ready is low in DONE even when out_ready=1.
- No combinational path from readReq_i_ready to readReq_i_valid, from out_ready to out_valid, or from cmd_valid to any output.

## Test plan
- Full group: cmd mask=4'hF, readLane={3,2,1,0}, crossbar always ready, lanes respond 1 cycle after fire with data 0xA0+slot -> all four requests in cycle 1; out_valid in cycle 3; out_bits_data={A3,A2,A1,A0}; error=0.
- Lane conflict: readLane all 2, crossbar grants one slot per cycle (slot 0 first) -> issues serialize over cycles 1-4; out_valid exactly once, one cycle after the last response; data correct per slot.
- Partial mask: mask=4'b0101 -> only readReq_0/2 valid; slots 1 and 3 read as 0; out_bits_mask=0101.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and data stay stable, cmd_ready=0; release -> IDLE the next cycle, cmd_ready=1.
- Violations: a response with writeIndex=1 while mask=0001, a duplicate response for slot 0, and a response in IDLE -> error=1 and stays 1; buffer is unchanged by the dropped responses.
- Reset mid-BUSY with 2 of 4 slots returned -> all outputs return to their reset values; a following mask=0 command produces out_valid in cycle 1.

Source files
------------

// File: rtl/mask_unit_read_collector.sv
// Mask-unit group read sequencer: issues up to four VRF reads through the crossbar
// slot channels and gathers tagged lane responses into one downstream group.
module mask_unit_read_collector #(
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4:0]            cmd_bits_vs,
    input  logic [1:0]            cmd_bits_offset,
    input  logic [3:0]            cmd_bits_mask,
    input  logic [7:0]            cmd_bits_readLane,
    input  logic [7:0]            cmd_bits_dataOffset,
    output logic                  readReq_0_valid,
    input  logic                  readReq_0_ready,
    output logic [4:0]            readReq_0_bits_vs,
    output logic [1:0]            readReq_0_bits_offset,
    output logic [1:0]            readReq_0_bits_readLane,
    output logic [1:0]            readReq_0_bits_dataOffset,
    output logic                  readReq_1_valid,
    input  logic                  readReq_1_ready,
    output logic [4:0]            readReq_1_bits_vs,
    output logic [1:0]            readReq_1_bits_offset,
    output logic [1:0]            readReq_1_bits_readLane,
    output logic [1:0]            readReq_1_bits_dataOffset,
    output logic                  readReq_2_valid,
    input  logic                  readReq_2_ready,
    output logic [4:0]            readReq_2_bits_vs,
    output logic [1:0]            readReq_2_bits_offset,
    output logic [1:0]            readReq_2_bits_readLane,
    output logic [1:0]            readReq_2_bits_dataOffset,
    output logic                  readReq_3_valid,
    input  logic                  readReq_3_ready,
    output logic [4:0]            readReq_3_bits_vs,
    output logic [1:0]            readReq_3_bits_offset,
    output logic [1:0]            readReq_3_bits_readLane,
    output logic [1:0]            readReq_3_bits_dataOffset,
    input  logic [3:0]            readResp_valid,
    input  logic [7:0]            readResp_writeIndex,
    input  logic [4*DATA_W-1:0]   readResp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DATA_W-1:0]   out_bits_data,
    output logic [3:0]            out_bits_mask,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT                 state, stateNext;
    logic [4:0]            vsReg;
    logic [1:0]            offsetReg;
    logic [3:0]            maskReg;
    logic [7:0]            laneReg;
    logic [7:0]            dataOffsetReg;
    logic [3:0]            issued;
    logic [3:0]            got;
    logic [3:0]            gotNext;
    logic [4*DATA_W-1:0]   dataBuf;
    logic [4*DATA_W-1:0]   bufNext;
    logic                  respErr;
    logic                  errorReg;
    logic [3:0]            reqValid;
    logic [3:0]            reqReady;
    logic [3:0]            reqFire;
    logic [1:0]            slotIdx;
    logic                  cmdFire;

    assign cmdFire  = cmd_valid && (state == IDLE);
    assign reqReady = {readReq_3_ready, readReq_2_ready, readReq_1_ready, readReq_0_ready};
    assign reqFire  = reqValid & reqReady;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (cmd_valid) stateNext = (cmd_bits_mask == 4'd0) ? DONE : BUSY;
            BUSY: if (gotNext == maskReg) stateNext = DONE;
            DONE: if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Everything visible here depends only on registered state, so ready inputs never loop back.
    always_comb begin
        cmd_ready = (state == IDLE);
        out_valid = (state == DONE);
        reqValid  = (state == BUSY) ? (maskReg & ~issued) : 4'd0;
    end

    // A response is only legal for an enabled slot whose request already fired in an
    // earlier cycle and that has not returned yet; gotNext also resolves lane collisions.
    always_comb begin
        gotNext = got;
        bufNext = dataBuf;
        respErr = 1'b0;
        slotIdx = 2'd0;
        for (int l = 0; l < 4; l++) begin
            if (readResp_valid[l]) begin
                slotIdx = readResp_writeIndex[2*l +: 2];
                if ((state == BUSY) && maskReg[slotIdx] && issued[slotIdx] && !gotNext[slotIdx]) begin
                    gotNext[slotIdx] = 1'b1;
                    bufNext[int'(slotIdx)*DATA_W +: DATA_W] = readResp_data[l*DATA_W +: DATA_W];
                end else begin
                    respErr = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsReg         <= '0;
            offsetReg     <= '0;
            maskReg       <= '0;
            laneReg       <= '0;
            dataOffsetReg <= '0;
            issued        <= '0;
            got           <= '0;
            dataBuf       <= '0;
            errorReg      <= 1'b0;
        end else begin
            if (cmdFire) begin
                vsReg         <= cmd_bits_vs;
                offsetReg     <= cmd_bits_offset;
                maskReg       <= cmd_bits_mask;
                laneReg       <= cmd_bits_readLane;
                dataOffsetReg <= cmd_bits_dataOffset;
                issued        <= '0;
                got           <= '0;
                dataBuf       <= '0;
            end else if (state == BUSY) begin
                issued  <= issued | reqFire;
                got     <= gotNext;
                dataBuf <= bufNext;
            end
            errorReg <= errorReg | respErr;
        end
    end

    assign readReq_0_valid           = reqValid[0];
    assign readReq_0_bits_vs         = vsReg;
    assign readReq_0_bits_offset     = offsetReg;
    assign readReq_0_bits_readLane   = laneReg[1:0];
    assign readReq_0_bits_dataOffset = dataOffsetReg[1:0];
    assign readReq_1_valid           = reqValid[1];
    assign readReq_1_bits_vs         = vsReg;
    assign readReq_1_bits_offset     = offsetReg;
    assign readReq_1_bits_readLane   = laneReg[3:2];
    assign readReq_1_bits_dataOffset = dataOffsetReg[3:2];
    assign readReq_2_valid           = reqValid[2];
    assign readReq_2_bits_vs         = vsReg;
    assign readReq_2_bits_offset     = offsetReg;
    assign readReq_2_bits_readLane   = laneReg[5:4];
    assign readReq_2_bits_dataOffset = dataOffsetReg[5:4];
    assign readReq_3_valid           = reqValid[3];
    assign readReq_3_bits_vs         = vsReg;
    assign readReq_3_bits_offset     = offsetReg;
    assign readReq_3_bits_readLane   = laneReg[7:6];
    assign readReq_3_bits_dataOffset = dataOffsetReg[7:6];

    assign out_bits_data = dataBuf;
    assign out_bits_mask = maskReg;
    assign error         = errorReg;

endmodule
